// File: rtl/sdram_arb_pkg.sv
// Shared state encoding and counter-width helpers for the SDRAM arbiter.
package sdram_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DefBeatCntW = cnt_width(8);
  localparam int DefWdogCntW = cnt_width(1024);

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Cycle watchdog: counts while run is high, pulses expire on the TimeoutCycles-th cycle.
module sdram_arb_watchdog
  import sdram_arb_pkg::*;
#(
  parameter int TimeoutCycles = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int W = cnt_width(TimeoutCycles);
  localparam logic [W-1:0] CntLast = W'(TimeoutCycles - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && cnt_q != CntLast) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign expire = run && !clear && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester (burst write / burst read) arbiter in front of an SDRAM controller.
// Optional grant statistics outputs are enabled with SDRAM_ARB_STATS_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AddressWidthSDRAM = 24,
  parameter int PixelBitWidth     = 16,
  parameter int BurstLengthSDRAM  = 8,
  parameter int MaxWriteStreak    = 4,
  parameter int TimeoutCycles     = 1024
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_wr_req,
  input  logic [AddressWidthSDRAM-1:0] i_wr_addr,
  input  logic [PixelBitWidth-1:0]     i_wr_data,
  output logic                         o_wr_pop,
  output logic                         o_wr_done,
  input  logic                         i_rd_req,
  input  logic [AddressWidthSDRAM-1:0] i_rd_addr,
  output logic [PixelBitWidth-1:0]     o_rd_data,
  output logic                         o_rd_valid,
  output logic                         o_rd_done,
  output logic                         o_sdram_enable,
  output logic                         o_sdram_read,
  output logic [AddressWidthSDRAM-1:0] o_sdram_addr,
  output logic [PixelBitWidth-1:0]     o_sdram_pixel,
  input  logic                         i_sdram_busy,
  input  logic                         i_sdram_valid_wr,
  input  logic                         i_sdram_valid_rd,
  input  logic [PixelBitWidth-1:0]     i_sdram_pixel,
  output logic                         o_error
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]                  o_wr_grants,
  output logic [15:0]                  o_rd_grants
`endif
);

  localparam int BeatW   = cnt_width(BurstLengthSDRAM);
  localparam int StreakW = cnt_width(MaxWriteStreak);
  localparam logic [BeatW-1:0]   BeatLast  = BeatW'(BurstLengthSDRAM);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxWriteStreak);

  logic [1:0]                   state_q, state_d;
  logic                         rd_q, rd_d;
  logic [AddressWidthSDRAM-1:0] addr_q, addr_d;
  logic                         en_q, en_d;
  logic [BeatW-1:0]             beat_q, beat_d;
  logic [StreakW-1:0]           streak_q, streak_d;
  logic                         err_q, err_d;
  logic [PixelBitWidth-1:0]     rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;

  logic in_xfer, beat_room, wr_beat, rd_beat;
  logic wr_grant, rd_grant;
  logic wd_run, wd_clear, wd_expire;

  assign in_xfer   = (state_q == ST_XFER);
  assign beat_room = (beat_q < BeatLast);
  assign wr_beat   = in_xfer && !rd_q && i_sdram_valid_wr && beat_room;
  assign rd_beat   = in_xfer &&  rd_q && i_sdram_valid_rd && beat_room;

  // Writes win ties until the streak limit is reached, then one read gets through.
  assign wr_grant = (state_q == ST_IDLE) && i_wr_req && (!i_rd_req || streak_q != StreakMax);
  assign rd_grant = (state_q == ST_IDLE) && i_rd_req && !wr_grant;

  assign wd_run   = (state_q == ST_ISSUE) || in_xfer;
  assign wd_clear = !wd_run;

  sdram_arb_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk   (CLK),
    .rst_n (RST),
    .run   (wd_run),
    .clear (wd_clear),
    .expire(wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    en_d       = en_q;
    beat_d     = beat_q;
    streak_d   = streak_q;
    err_d      = 1'b0;
    rd_valid_d = rd_beat;
    rd_data_d  = rd_beat ? i_sdram_pixel : rd_data_q;
    if (wr_beat || rd_beat) begin
      beat_d = beat_q + BeatW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (wr_grant) begin
          state_d = ST_ISSUE;
          rd_d    = 1'b0;
          addr_d  = i_wr_addr;
          en_d    = 1'b1;
          beat_d  = '0;
          if (!i_rd_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (rd_grant) begin
          state_d  = ST_ISSUE;
          rd_d     = 1'b1;
          addr_d   = i_rd_addr;
          en_d     = 1'b1;
          beat_d   = '0;
          streak_d = '0;
        end
      end
      ST_ISSUE: begin
        if (i_sdram_busy) begin
          en_d    = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!i_sdram_busy) begin
          state_d = ST_DONE;
          err_d   = (beat_d < BeatLast);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stuck controller abandons the transaction silently apart from the error pulse.
    if (wd_expire) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      beat_q     <= '0;
      streak_q   <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      beat_q     <= beat_d;
      streak_q   <= streak_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_sdram_enable = en_q;
  assign o_sdram_read   = rd_q;
  assign o_sdram_addr   = addr_q;
  assign o_sdram_pixel  = (in_xfer && !rd_q) ? i_wr_data : '0;
  assign o_wr_pop       = wr_beat;
  assign o_wr_done      = (state_q == ST_DONE) && !rd_q;
  assign o_rd_done      = (state_q == ST_DONE) &&  rd_q;
  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_error        = err_q;

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] wr_grants_q, wr_grants_d;
  logic [15:0] rd_grants_q, rd_grants_d;

  always_comb begin
    wr_grants_d = wr_grants_q;
    rd_grants_d = rd_grants_q;
    if (wr_grant && wr_grants_q != 16'hFFFF) wr_grants_d = wr_grants_q + 16'd1;
    if (rd_grant && rd_grants_q != 16'hFFFF) rd_grants_d = rd_grants_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_grants_q <= '0;
      rd_grants_q <= '0;
    end else begin
      wr_grants_q <= wr_grants_d;
      rd_grants_q <= rd_grants_d;
    end
  end

  assign o_wr_grants = wr_grants_q;
  assign o_rd_grants = rd_grants_q;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus pushes expected grants, beats and
// done/error events; a negedge monitor pops and compares as the DUT presents them.
module tb_sdram_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        i_wr_req = 1'b0, i_rd_req = 1'b0;
  logic [23:0] i_wr_addr = '0, i_rd_addr = '0;
  logic [15:0] i_wr_data;
  logic        o_wr_pop, o_wr_done, o_rd_valid, o_rd_done;
  logic [15:0] o_rd_data;
  logic        o_sdram_enable, o_sdram_read;
  logic [23:0] o_sdram_addr;
  logic [15:0] o_sdram_pixel;
  logic        i_sdram_busy = 1'b0, i_sdram_valid_wr = 1'b0, i_sdram_valid_rd = 1'b0;
  logic [15:0] i_sdram_pixel = '0;
  logic        o_error;

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_grant[$];
  logic [15:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [2:0]  exp_evt[$];

  logic [15:0] wr_head = 16'hA000;
  logic [15:0] exp_wr_next = 16'hA000;
  assign i_wr_data = wr_head;

  always #5 CLK = ~CLK;

  sdram_arbiter #(
    .AddressWidthSDRAM(24),
    .PixelBitWidth    (16),
    .BurstLengthSDRAM (8),
    .MaxWriteStreak   (4),
    .TimeoutCycles    (16)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .i_wr_req        (i_wr_req),
    .i_wr_addr       (i_wr_addr),
    .i_wr_data       (i_wr_data),
    .o_wr_pop        (o_wr_pop),
    .o_wr_done       (o_wr_done),
    .i_rd_req        (i_rd_req),
    .i_rd_addr       (i_rd_addr),
    .o_rd_data       (o_rd_data),
    .o_rd_valid      (o_rd_valid),
    .o_rd_done       (o_rd_done),
    .o_sdram_enable  (o_sdram_enable),
    .o_sdram_read    (o_sdram_read),
    .o_sdram_addr    (o_sdram_addr),
    .o_sdram_pixel   (o_sdram_pixel),
    .i_sdram_busy    (i_sdram_busy),
    .i_sdram_valid_wr(i_sdram_valid_wr),
    .i_sdram_valid_rd(i_sdram_valid_rd),
    .i_sdram_pixel   (i_sdram_pixel),
    .o_error         (o_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: consumes expectations whenever the DUT presents an output.
  logic        prev_en = 1'b0;
  logic        prev_vrd = 1'b0;
  logic [24:0] mon_g;
  logic [15:0] mon_d;
  logic [2:0]  mon_e;

  always @(negedge CLK) begin
    if (RST) begin
      if (o_sdram_enable && !prev_en) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", 64'd1, 64'd0);
        else begin
          mon_g = exp_grant.pop_front();
          chk("grant", {39'd0, o_sdram_read, o_sdram_addr}, {39'd0, mon_g});
        end
      end
      if (o_wr_pop) begin
        if (exp_wr.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
        else begin
          mon_d = exp_wr.pop_front();
          chk("wr_pixel", {48'd0, o_sdram_pixel}, {48'd0, mon_d});
        end
        wr_head = wr_head + 16'd1;
      end
      if (o_rd_valid) begin
        chk("rd_latency", {63'd0, prev_vrd}, 64'd1);
        if (exp_rd.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
        else begin
          mon_d = exp_rd.pop_front();
          chk("rd_data", {48'd0, o_rd_data}, {48'd0, mon_d});
        end
      end
      if (o_wr_done || o_rd_done || o_error) begin
        if (exp_evt.size() == 0) chk("event_unexpected", {61'd0, o_wr_done, o_rd_done, o_error}, 64'd0);
        else begin
          mon_e = exp_evt.pop_front();
          chk("done_err", {61'd0, o_wr_done, o_rd_done, o_error}, {61'd0, mon_e});
        end
      end
    end
    prev_en  = o_sdram_enable;
    prev_vrd = i_sdram_valid_rd;
  end

  task automatic wait_en(output bit ok);
    for (int k = 0; k < 50 && !o_sdram_enable; k++) tick();
    ok = o_sdram_enable;
    if (!ok) chk("enable_timeout", 64'd0, 64'd1);
  endtask

  // Plays the controller for one full transaction and queues all expectations.
  task automatic xact(input bit rd, input logic [23:0] addr, input int xfer_cycles,
                      input int nbeats, input bit drop);
    bit ok;
    int nb;
    nb = (nbeats > 8) ? 8 : nbeats;
    exp_grant.push_back({rd, addr});
    for (int i = 0; i < nb; i++) begin
      if (rd) exp_rd.push_back(16'(i + 1));
      else begin
        exp_wr.push_back(exp_wr_next);
        exp_wr_next = exp_wr_next + 16'd1;
      end
    end
    exp_evt.push_back({!rd, rd, (nbeats < 8)});
    wait_en(ok);
    if (ok) begin
      if (drop) begin
        i_wr_req = 1'b0;
        i_rd_req = 1'b0;
      end
      i_sdram_busy = 1'b1;
      tick();
      for (int c = 0; c < xfer_cycles; c++) begin
        i_sdram_valid_wr = !rd && (c < nbeats);
        i_sdram_valid_rd =  rd && (c < nbeats);
        i_sdram_pixel    = 16'(c + 1);
        tick();
      end
      i_sdram_busy     = 1'b0;
      i_sdram_valid_wr = 1'b0;
      i_sdram_valid_rd = 1'b0;
      tick();
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {1'b0, o_sdram_enable, o_sdram_read, o_sdram_addr, o_sdram_pixel, o_wr_pop,
            o_wr_done, o_rd_data, o_rd_valid, o_rd_done, o_error};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit ok;
    int n;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 64'd0);
    RST = 1'b1;
    repeat (2) tick();
    chk("idle_outputs", all_outs(), 64'd0);

    // Write only, 11 busy XFER cycles with 8 accepted beats; request dropped after grant.
    i_wr_addr = 24'h000100;
    i_wr_req  = 1'b1;
    xact(1'b0, 24'h000100, 11, 8, 1'b1);

    // Read only, data 1..8.
    i_rd_addr = 24'h000200;
    i_rd_req  = 1'b1;
    xact(1'b1, 24'h000200, 10, 8, 1'b1);

    // Read with 10 offered beats: only 8 forwarded.
    i_rd_req = 1'b1;
    xact(1'b1, 24'h000200, 11, 10, 1'b1);

    // Both requests held: W,W,W,W,R repeating.
    i_wr_req = 1'b1;
    i_rd_req = 1'b1;
    for (int t = 0; t < 10; t++) begin
      xact((t % 5) == 4, (t % 5) == 4 ? 24'h000200 : 24'h000100, 8, 8, t == 9);
    end

    // Controller never goes busy: watchdog fires after 16 cycles.
    i_wr_addr = 24'h000300;
    i_wr_req  = 1'b1;
    exp_grant.push_back({1'b0, 24'h000300});
    exp_evt.push_back(3'b001);
    wait_en(ok);
    i_wr_req = 1'b0;
    n = 0;
    while (!o_error && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycle", 64'(n), 64'd16);
    chk("timeout_en_low", {63'd0, o_sdram_enable}, 64'd0);
    repeat (3) tick();

    // Next request after timeout is granted normally.
    i_wr_addr = 24'h000110;
    i_wr_req  = 1'b1;
    xact(1'b0, 24'h000110, 8, 8, 1'b1);

    // Short burst: busy falls after 5 beats, done and error together.
    i_wr_req = 1'b1;
    xact(1'b0, 24'h000110, 6, 5, 1'b1);

    // Reset during XFER of a read: everything returns to 0 with no done/error.
    i_rd_addr = 24'h000400;
    i_rd_req  = 1'b1;
    exp_grant.push_back({1'b1, 24'h000400});
    wait_en(ok);
    i_rd_req     = 1'b0;
    i_sdram_busy = 1'b1;
    tick();
    #2 RST = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 64'd0);
    tick();
    i_sdram_busy = 1'b0;
    tick();
    RST = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", all_outs(), 64'd0);

    // Fresh write after reset.
    i_wr_addr = 24'h000120;
    i_wr_req  = 1'b1;
    xact(1'b0, 24'h000120, 9, 8, 1'b1);

    repeat (5) tick();
    chk("grant_q_empty", 64'(exp_grant.size()), 64'd0);
    chk("wr_q_empty", 64'(exp_wr.size()), 64'd0);
    chk("rd_q_empty", 64'(exp_rd.size()), 64'd0);
    chk("evt_q_empty", 64'(exp_evt.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
